seg_scan4: RTL
==============

# seg_scan4

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It accepts four packed BCD digits from the counter chain and turns them into segment and anode patterns. One digit is lit at a time, and the block steps to the next digit every `SCAN_DIV` clocks. Input digits are captured once per frame so a counter rolling over mid-scan never shows a torn value.

## Interface
- `SCAN_DIV`, default 50000: clocks per digit slot; legal range ≥ 2; prescaler width is `$clog2(SCAN_DIV)`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `digits` in 16: BCD digits, `[3:0]` = digit 0 (rightmost) … `[15:12]` = digit 3 (leftmost).
- `dp_in` in 4: decimal-point request per digit, active-high, bit n = digit n.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: anode enables, active-low, bit n = digit n.
- `frame_tick` out 1: one-cycle pulse marking the start of each frame (digit 0 slot).

## Operation
- Prescaler `pre` counts 0…`SCAN_DIV`-1 and wraps. Terminal count `tc` = (`pre` == `SCAN_DIV`-1).
- Digit index `sel` is 2 bits and resets to 3. On `tc`, `sel` ← `sel`+1 mod 4, so the first `tc` selects digit 0.
- Frame capture: on a `tc` where `sel` == 3:
  - shadow ← `digits`, dp shadow ← `dp_in`.
  - `frame_tick` ← 1 for that cycle. It is 0 in all other cycles.
- Outputs are registered and update only on `tc`:
  - `an` ← `~(4'b0001 << next_sel)`.
  - `seg` ← decode of the shadow nibble for `next_sel`.
  - `dp` ← `~dp shadow[next_sel]`.
  - For digit 0, the decode and dp use the values being captured on that same edge (bypass), not the stale shadow.
- Decode, active-low, value → `seg`:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000
  - 10–15 (non-BCD) → 1111111, i.e. blank; `an` still steps normally.
- Input changes between frame captures have no effect on the outputs.

## Timing
- Reset values:
  - `pre`=0, `sel`=3, shadow=0, dp shadow=0.
  - `an`=1111, `seg`=1111111, `dp`=1, `frame_tick`=0.
  - The display stays dark until the first `tc`.
- First `tc` occurs on the `SCAN_DIV`-th rising edge after `rst` deasserts. On that edge:
  - `an`=1110.
  - `seg` decodes `digits[3:0]` as sampled on that edge.
  - `frame_tick`=1.
- Each digit is held for exactly `SCAN_DIV` cycles. Frame period is 4×`SCAN_DIV` cycles.
- Latency from input capture to display is 0 cycles for digit 0, and n×`SCAN_DIV` cycles for digit n.
- Exactly one `an` bit is low at any time after the first `tc`.
- `rst` asserted mid-frame forces all reset values immediately, without waiting for a clock edge. The scan restarts from the reset sequence.

## Configuration
- `SEG_SCAN4_LZ_BLANK_EN` defined: leading-zero blanking is compiled in.
  - Digit n (n = 3, 2, 1) shows `seg`=1111111 and `dp`=1 when its captured value is 0 and all captured digits above it are 0.
  - Digit 0 is never blanked by this rule.
  - `an` timing is unchanged.
- Macro undefined: zeros display as "0" on every digit.

## Test plan
- `SCAN_DIV`=4, `digits`=16'h1234, `dp_in`=0, release reset:
  - `an`/`seg` is 1110/0011001 at edge 4, 1101/0110000 at edge 8, 1011/0100100 at edge 12, 0111/1111001 at edge 16.
  - `frame_tick` is high only on edges 4 and 20.
- Tearing check: change `digits` to 16'h5678 during the digit 2 slot. The current frame still shows 2 then 1; the next frame shows 8, 7, 6, 5.
- `digits`=16'hA9F0 → `seg` sequence 1000000, 1111111, 0010000, 1111111, with `an` stepping normally.
- `dp_in`=4'b0100 → `dp`=0 only while `an`=1011, else 1.
- Assert `rst` mid-slot 2 → outputs go to 1111/1111111/1 asynchronously. After release, the first lit digit is digit 0, `SCAN_DIV` cycles later.
- With `SEG_SCAN4_LZ_BLANK_EN`, `digits`=16'h0050:
  - Digits 3 and 2 are blank.
  - Digit 1 shows 0010010 (5).
  - Digit 0 shows 1000000 (0).
  - Without the macro, digits 3 and 2 show 1000000.

Source files
------------

// File: rtl/seg_scan4.sv
// seg_scan4 -- time-multiplexed driver for a 4-digit common-anode
// seven-segment display.
//
// One digit is lit at a time; the scan advances every SCAN_DIV clocks, so a
// full frame (digits 0,1,2,3) lasts 4*SCAN_DIV clocks. The BCD digits and
// decimal-point requests are captured once per frame, at the start of the
// digit 0 slot, so a counter rolling over mid-scan never shows a torn value.
//
// Parameters:
//   SCAN_DIV   clocks per digit slot (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   digits      packed BCD, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   dp_in       decimal-point request per digit, active-high, bit n = digit n
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   an          anode enables, active-low, bit n = digit n
//   frame_tick  one-cycle pulse at the start of each frame (digit 0 slot)
//
// Build option:
//   SEG_SCAN4_LZ_BLANK_EN  when defined, leading zeros on digits 3..1 are
//                          blanked (segments and decimal point off). Digit 0
//                          always shows its value.
//
// There are no handshakes: inputs are level-sampled on the frame capture
// edge and outputs are plain registered levels.

module seg_scan4 #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int             PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

    // Active-low BCD to seven-segment decode; non-BCD codes are blank.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] pre;
    logic [1:0]    sel;
    logic [15:0]   shadow;
    logic [3:0]    dp_shadow;

    // ------------------------------------------------------------------
    // Combinational scan control
    // ------------------------------------------------------------------
    logic        tc;
    logic        capture;
    logic [1:0]  next_sel;
    logic [15:0] cur_frame;
    logic [3:0]  cur_dp;
    logic [3:0]  nib;
    logic        dp_req;
    logic        lz_blank;
    logic [6:0]  seg_next;
    logic        dp_next;
    logic [3:0]  an_next;

    assign tc       = (pre == PRE_LAST);
    assign capture  = tc && (sel == 2'd3);
    assign next_sel = sel + 2'd1;

    // On the capture edge the digit 0 slot must show the value being captured
    // right now, not the previous frame, so the shadow is bypassed.
    assign cur_frame = capture ? digits : shadow;
    assign cur_dp    = capture ? dp_in  : dp_shadow;

    always_comb begin
        nib    = 4'd0;
        dp_req = 1'b0;
        case (next_sel)
            2'd0: begin nib = cur_frame[3:0];   dp_req = cur_dp[0]; end
            2'd1: begin nib = cur_frame[7:4];   dp_req = cur_dp[1]; end
            2'd2: begin nib = cur_frame[11:8];  dp_req = cur_dp[2]; end
            2'd3: begin nib = cur_frame[15:12]; dp_req = cur_dp[3]; end
            default: begin nib = 4'd0; dp_req = 1'b0; end
        endcase
    end

`ifdef SEG_SCAN4_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_blank = 1'b0;
        case (next_sel)
            2'd1:    lz_blank = (cur_frame[15:4]  == 12'd0);
            2'd2:    lz_blank = (cur_frame[15:8]  == 8'd0);
            2'd3:    lz_blank = (cur_frame[15:12] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign seg_next = lz_blank ? 7'b1111111 : decode(nib);
    assign dp_next  = lz_blank ? 1'b1       : ~dp_req;
    assign an_next  = ~(4'b0001 << next_sel);

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            sel <= 2'd3;   // first terminal count steps to digit 0
        end else begin
            if (tc) begin
                pre <= '0;
                sel <= next_sel;
            end else begin
                pre <= pre + PRE_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= 16'd0;
            dp_shadow  <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= capture;
            if (capture) begin
                shadow    <= digits;
                dp_shadow <= dp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered display outputs, updated only at slot boundaries
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (tc) begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
